wb_mem_arbiter: RTL and testbench

Round-robin Wishbone B3 arbiter that shares the single on-chip memory slave between NUM_MASTERS masters (CPU instruction/data ports, debug unit) in the multi-core SoC top. It grants one master at a time and holds the grant for the whole bus cycle, including incrementing bursts. Slave responses are routed back only to the granted master. An optional watchdog terminates hung cycles with an error.

---
 rtl/wb_mem_arbiter_pkg.sv | 33 +++
 rtl/wb_mem_arbiter_if.sv | 56 +++++
 rtl/wb_mem_arbiter_rr_picker.sv | 34 +++
 rtl/wb_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_mem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// wb_mem_arbiter_pkg : FSM encoding and Wishbone B3 CTI/BTE constants
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wb_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    localparam int unsigned MAX_MASTERS = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_mem_arbiter_if.sv
//------------------------------------------------------------------------------
// wb_mem_arbiter_if : master-side and slave-side Wishbone signals of the arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface wb_mem_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
) ();

    logic [NUM_MASTERS*AW-1:0]     m_adr_i;
    logic [NUM_MASTERS*DW-1:0]     m_dat_i;
    logic [NUM_MASTERS*(DW/8)-1:0] m_sel_i;
    logic [NUM_MASTERS-1:0]        m_we_i;
    logic [NUM_MASTERS-1:0]        m_cyc_i;
    logic [NUM_MASTERS-1:0]        m_stb_i;
    logic [NUM_MASTERS*3-1:0]      m_cti_i;
    logic [NUM_MASTERS*2-1:0]      m_bte_i;
    logic [DW-1:0]                 m_dat_o;
    logic [NUM_MASTERS-1:0]        m_ack_o;
    logic [NUM_MASTERS-1:0]        m_err_o;
    logic [NUM_MASTERS-1:0]        m_rty_o;

    logic [AW-1:0]                 s_adr_o;
    logic [DW-1:0]                 s_dat_o;
    logic [DW/8-1:0]               s_sel_o;
    logic                          s_we_o;
    logic                          s_cyc_o;
    logic                          s_stb_o;
    logic [2:0]                    s_cti_o;
    logic [1:0]                    s_bte_o;
    logic [DW-1:0]                 s_dat_i;
    logic                          s_ack_i;
    logic                          s_err_i;
    logic                          s_rty_i;

    // The arbiter itself is the slave of the masters; the environment holds the master view.
    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

endinterface

`default_nettype wire

// File: rtl/wb_mem_arbiter_rr_picker.sv
//------------------------------------------------------------------------------
// wb_arb_rr_picker : combinational round-robin priority encoder
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_arb_rr_picker #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned IDXW        = 1
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDXW-1:0]        last_grant_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   valid_o
);

    // Search starts just above the last winner, so it always ends up lowest priority.
    always_comb begin
        logic [IDXW-1:0] idx;
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
            idx = IDXW'((32'(last_grant_i) + 32'(k)) % NUM_MASTERS);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_mem_arbiter.sv
//------------------------------------------------------------------------------
// wb_mem_arbiter : round-robin Wishbone B3 arbiter, one grant per bus cycle.
// Optional watchdog abort enabled by defining WB_ARB_TIMEOUT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    wb_mem_arbiter_if.slave        bus,
    output logic [NUM_MASTERS-1:0] grant_o
);

    localparam int unsigned IDXW = idx_width(NUM_MASTERS);
    localparam int unsigned SW   = DW / 8;

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
        $error("wb_mem_arbiter: NUM_MASTERS must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_mem_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDXW-1:0]        last_q, last_d;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;
    logic [IDXW-1:0]        pick_idx;

    logic [AW-1:0]          own_adr;
    logic [DW-1:0]          own_dat;
    logic [SW-1:0]          own_sel;
    logic                   own_we, own_cyc, own_stb;
    logic [2:0]             own_cti;
    logic [1:0]             own_bte;
    logic                   busy;
    logic                   timeout_hit;

    wb_arb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDXW        (IDXW)
    ) u_picker (
        .req_i        (bus.m_cyc_i),
        .last_grant_i (last_q),
        .gnt_o        (pick_gnt),
        .valid_o      (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (pick_gnt[i]) pick_idx = IDXW'(i);
        end
    end

    // last_q doubles as the owner index while a grant is held.
    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_cti = '0;
        own_bte = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (IDXW'(i) == last_q) begin
                own_adr = bus.m_adr_i[i*AW +: AW];
                own_dat = bus.m_dat_i[i*DW +: DW];
                own_sel = bus.m_sel_i[i*SW +: SW];
                own_we  = bus.m_we_i[i];
                own_cyc = bus.m_cyc_i[i];
                own_stb = bus.m_stb_i[i];
                own_cti = bus.m_cti_i[i*3 +: 3];
                own_bte = bus.m_bte_i[i*2 +: 2];
            end
        end
    end

    assign busy = (state_q == ST_BUSY);

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic        slave_resp;

    assign slave_resp = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !busy || slave_resp) begin
            wdog_q <= '0;
        end else if (bus.s_stb_o) begin
            wdog_q <= wdog_q + 16'd1;
        end
    end

    // Fires during the TIMEOUT_CYCLES-th unanswered strobe cycle.
    assign timeout_hit = busy && own_stb && (wdog_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDXW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_BUSY;
                    grant_d = pick_gnt;
                    last_d  = pick_idx;
                end
            end
            ST_BUSY: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_ABORT: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.s_adr_o = own_adr;
    assign bus.s_dat_o = own_dat;
    assign bus.s_sel_o = own_sel;
    assign bus.s_cti_o = own_cti;
    assign bus.s_bte_o = own_bte;
    assign bus.s_we_o  = busy & own_we;
    assign bus.s_cyc_o = busy & own_cyc & ~timeout_hit;
    assign bus.s_stb_o = busy & own_stb & ~timeout_hit;

    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_ack_o = grant_q & {NUM_MASTERS{busy & bus.s_ack_i & ~timeout_hit}};
    assign bus.m_err_o = grant_q & {NUM_MASTERS{busy & (bus.s_err_i | timeout_hit)}};
    assign bus.m_rty_o = grant_q & {NUM_MASTERS{busy & bus.s_rty_i & ~timeout_hit}};

    assign grant_o = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_wb_mem_arbiter : directed scenarios plus random traffic against a
// transaction-level arbitration model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_mem_arbiter;
    import wb_mem_arbiter_pkg::*;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] grant;

    wb_mem_arbiter_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) bus ();

    wb_mem_arbiter #(
        .NUM_MASTERS    (N),
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus),
        .grant_o  (grant)
    );

    always #5 clk = ~clk;

    int n_cmp, n_mis;

    // master engines
    int            rem    [N];
    logic [AW-1:0] cadr   [N];
    logic          cwe    [N];
    bit            cburst [N];
    int            idle_w [N];
    bit            auto_on;
    int            slv_mode;   // 0 random, 1 always ack, 2 never respond, 3 error once then ack

    // arbitration model
    int m_owner, m_last, m_run;
    bit m_abort;

    logic [N-1:0]  obs_grant, obs_ack, obs_err, obs_rty, prev_grant;
    logic          obs_scyc;
    int            gnt_log[$];
    logic [AW-1:0] adr1_log[$];
    int            err0_cnt, err1_cnt, n_stb, stb_before_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit any_active();
        bit a;
        a = 1'b0;
        for (int i = 0; i < int'(N); i++) if (rem[i] > 0) a = 1'b1;
        return a;
    endfunction

    task automatic start_txn(input int i, input logic [AW-1:0] adr, input int beats, input logic we);
        rem[i]    = beats;
        cadr[i]   = adr;
        cwe[i]    = we;
        cburst[i] = (beats > 1);
        idle_w[i] = $urandom_range(3);
    endtask

    task automatic drive_masters();
        for (int i = 0; i < int'(N); i++) begin
            logic act;
            act = (rem[i] > 0);
            bus.m_cyc_i[i]              = act;
            bus.m_stb_i[i]              = act;
            bus.m_we_i[i]               = cwe[i];
            bus.m_adr_i[i*AW +: AW]     = cadr[i];
            bus.m_dat_i[i*DW +: DW]     = DW'($urandom);
            bus.m_sel_i[i*(DW/8) +: DW/8] = '1;
            bus.m_cti_i[i*3 +: 3]       = !cburst[i] ? CTI_CLASSIC : ((rem[i] > 1) ? CTI_INCR : CTI_EOB);
            bus.m_bte_i[i*2 +: 2]       = BTE_LINEAR;
        end
    endtask

    // One bus cycle: drive, respond as slave, check against the model, clock, advance.
    task automatic step();
        logic          sa, se, sr, owned, hit, own_cyc, own_stb;
        logic [DW-1:0] sd;
        logic [N-1:0]  oh, cyc_now, stb_now;
        int            o, r;
        drive_masters();
        #1;
        sa = 1'b0; se = 1'b0; sr = 1'b0;
        sd = DW'($urandom);
        if (bus.s_cyc_o && bus.s_stb_o) begin
            case (slv_mode)
                0: begin
                    r = $urandom_range(99);
                    if (r < 5) se = 1'b1;
                    else if (r < 10) sr = 1'b1;
                    else if (r < 60) sa = 1'b1;
                end
                1: sa = 1'b1;
                3: begin se = 1'b1; slv_mode = 1; end
                default: ;
            endcase
        end
        bus.s_ack_i = sa; bus.s_err_i = se; bus.s_rty_i = sr; bus.s_dat_i = sd;
        #1;
        cyc_now = bus.m_cyc_i;
        stb_now = bus.m_stb_i;
        o       = m_owner;
        owned   = (o >= 0) && !m_abort;
        oh      = '0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        if (o >= 0) begin
            oh[o]   = 1'b1;
            own_cyc = cyc_now[o];
            own_stb = stb_now[o];
        end
        hit = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        hit = owned && own_stb && (m_run == int'(TO) - 1);
`endif
        check_eq("grant", grant, oh);
        check_eq("s_cyc", bus.s_cyc_o, owned && own_cyc && !hit);
        check_eq("s_stb", bus.s_stb_o, owned && own_stb && !hit);
        check_eq("s_we", bus.s_we_o, owned && cwe[(o >= 0) ? o : 0]);
        if (owned && !hit) begin
            check_eq("s_adr", bus.s_adr_o, cadr[o]);
            check_eq("s_cti", bus.s_cti_o, bus.m_cti_i[o*3 +: 3]);
        end
        check_eq("m_ack", bus.m_ack_o, (owned && !hit && sa) ? oh : {N{1'b0}});
        check_eq("m_err", bus.m_err_o, (owned && (hit || se)) ? oh : {N{1'b0}});
        check_eq("m_rty", bus.m_rty_o, (owned && !hit && sr) ? oh : {N{1'b0}});
        check_eq("m_dat", bus.m_dat_o, sd);

        obs_grant = grant;
        obs_ack   = bus.m_ack_o;
        obs_err   = bus.m_err_o;
        obs_rty   = bus.m_rty_o;
        obs_scyc  = bus.s_cyc_o;
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < int'(N); i++) if (grant[i]) gnt_log.push_back(i);
        end
        prev_grant = grant;
        if (bus.m_ack_o[1]) adr1_log.push_back(bus.s_adr_o);
        if (bus.m_err_o[0]) err0_cnt++;
        if (bus.m_err_o[1]) err1_cnt++;
        if (bus.m_err_o[0] && stb_before_err < 0) stb_before_err = n_stb;
        if (bus.s_stb_o) n_stb++;

        @(posedge clk);
        if (rst) begin
            m_owner = -1; m_last = int'(N) - 1; m_abort = 1'b0; m_run = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= int'(N); k++) begin
                int idx;
                idx = (m_last + k) % int'(N);
                if (m_owner < 0 && cyc_now[idx]) begin
                    m_owner = idx; m_last = idx; m_run = 0;
                end
            end
        end else if (!cyc_now[m_owner]) begin
            m_owner = -1; m_abort = 1'b0;
        end else if (hit) begin
            m_abort = 1'b1;
        end else if (owned) begin
            if (sa || se || sr) m_run = 0;
            else if (own_stb) m_run++;
        end

        for (int i = 0; i < int'(N); i++) begin
            if (rem[i] > 0) begin
                if (obs_err[i]) rem[i] = 0;
                else if (obs_ack[i]) begin rem[i]--; cadr[i] += 4; end
            end else if (auto_on) begin
                if (idle_w[i] > 0) idle_w[i]--;
                else start_txn(i, {$urandom_range(1023), 2'b00}, $urandom_range(1, 4), 1'($urandom));
            end
        end
        #1;
    endtask

    task automatic run_until_quiet(input int budget);
        int c;
        c = 0;
        do begin
            step();
            c++;
        end while ((any_active() || obs_grant != '0) && c < budget);
        check_eq("quiet", {63'd0, any_active() || obs_grant != '0}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_mis = 0;
        auto_on = 1'b0; slv_mode = 1;
        for (int i = 0; i < int'(N); i++) begin
            rem[i] = 0; cadr[i] = '0; cwe[i] = 1'b0; cburst[i] = 1'b0; idle_w[i] = 0;
        end
        err0_cnt = 0; err1_cnt = 0; n_stb = 0; stb_before_err = -1;
        prev_grant = '0; obs_grant = '0;
        bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0; bus.s_dat_i = '0;
        drive_masters();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check_eq("rst_grant", grant, 0);
        check_eq("rst_s_cyc", bus.s_cyc_o, 0);
        check_eq("rst_s_stb", bus.s_stb_o, 0);
        check_eq("rst_m_ack", bus.m_ack_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_owner = -1; m_last = int'(N) - 1; m_abort = 1'b0; m_run = 0;

        // single request: one-cycle arbitration latency, ack to m0 only
        repeat (3) step();
        start_txn(0, 32'h100, 1, 1'b0);
        step();
        check_eq("t1_pre_scyc", obs_scyc, 0);
        check_eq("t1_pre_grant", obs_grant, 0);
        step();
        check_eq("t1_scyc", obs_scyc, 1);
        check_eq("t1_grant", obs_grant, 2'b01);
        check_eq("t1_ack", obs_ack, 2'b01);
        run_until_quiet(20);

        // simultaneous requests alternate
        do_reset();
        gnt_log.delete();
        start_txn(0, 32'h10, 1, 1'b1); start_txn(1, 32'h20, 1, 1'b1);
        run_until_quiet(20);
        start_txn(0, 32'h14, 1, 1'b1); start_txn(1, 32'h24, 1, 1'b1);
        run_until_quiet(20);
        check_eq("t2_count", gnt_log.size(), 4);
        for (int k = 0; k < 4; k++) check_eq($sformatf("t2_order%0d", k), gnt_log[k], k % 2);

        // burst hold
        gnt_log.delete(); adr1_log.delete();
        start_txn(1, 32'h200, 4, 1'b0);
        step();
        start_txn(0, 32'h300, 1, 1'b0);
        run_until_quiet(40);
        check_eq("t3_count", gnt_log.size(), 2);
        check_eq("t3_first", gnt_log[0], 1);
        check_eq("t3_second", gnt_log[1], 0);
        check_eq("t3_beats", adr1_log.size(), 4);
        for (int k = 0; k < 4; k++) check_eq($sformatf("t3_adr%0d", k), adr1_log[k], 32'h200 + 32'(4 * k));

        // error routing
        gnt_log.delete(); err0_cnt = 0; err1_cnt = 0;
        slv_mode = 3;
        start_txn(0, 32'h40, 1, 1'b0);
        step();
        start_txn(1, 32'h44, 1, 1'b0);
        run_until_quiet(20);
        check_eq("t4_err0", err0_cnt, 1);
        check_eq("t4_err1", err1_cnt, 0);
        check_eq("t4_count", gnt_log.size(), 2);
        check_eq("t4_next", gnt_log[1], 1);

        // reset during beat 2 of a burst
        slv_mode = 1;
        start_txn(0, 32'h500, 4, 1'b0);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        gnt_log.delete();
        start_txn(1, 32'h600, 1, 1'b0);
        step();
        check_eq("t5_grant", obs_grant, 0);
        check_eq("t5_scyc", obs_scyc, 0);
        run_until_quiet(40);
        check_eq("t5_first", gnt_log[0], 0);
        check_eq("t5_count", gnt_log.size(), 2);

`ifdef WB_ARB_TIMEOUT_EN
        // watchdog abort on a silent slave
        gnt_log.delete(); err0_cnt = 0; n_stb = 0; stb_before_err = -1;
        slv_mode = 2;
        start_txn(0, 32'h700, 1, 1'b0);
        step();
        start_txn(1, 32'h704, 1, 1'b0);
        for (int c = 0; c < 40 && err0_cnt == 0; c++) step();
        slv_mode = 1;
        run_until_quiet(40);
        check_eq("t6_err_once", err0_cnt, 1);
        check_eq("t6_err_at", stb_before_err, int'(TO) - 1);
        check_eq("t6_count", gnt_log.size(), 2);
        check_eq("t6_next", gnt_log[1], 1);
`endif

        // random traffic with occasional resets
        do_reset();
        auto_on = 1'b1; slv_mode = 0;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0;
        auto_on = 1'b0; slv_mode = 1;
        run_until_quiet(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

`default_nettype wire
